regop_sequencer: RTL and testbench

- Single-port execute sequencer that sits directly downstream of the 8x16 register file.
- Drives the regfile's readnum, writenum, write and data_in, and consumes its combinational data_out.
- Performs one two-operand ALU operation per start: reads Rn, then reads Rm, shifts B, computes, and writes the result back to Rd.
- Provides the operand/ALU/writeback stage that the regfile feeds, and exports status flags.

---
 rtl/regop_sequencer_if.sv | 31 +++
 rtl/regop_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_regop_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/regop_sequencer_if.sv
// Bundle between regop_sequencer and its register file / requester:
// operation request, regfile read/write port and status outputs.
interface regop_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          start;
    logic [1:0]    opcode;
    logic [1:0]    shift;
    logic [AW-1:0] rn;
    logic [AW-1:0] rm;
    logic [AW-1:0] rd;
    logic [DW-1:0] rf_data_out;
    logic [AW-1:0] readnum;
    logic [AW-1:0] writenum;
    logic          write;
    logic [DW-1:0] data_in;
    logic          busy;
    logic          done;
    logic [2:0]    status;

    modport master (
        output start, opcode, shift, rn, rm, rd, rf_data_out,
        input  readnum, writenum, write, data_in, busy, done, status
    );

    modport slave (
        input  start, opcode, shift, rn, rm, rd, rf_data_out,
        output readnum, writenum, write, data_in, busy, done, status
    );
endinterface

// File: rtl/regop_sequencer.sv
// Two-operand execute sequencer: reads Rn, Rm, shifts B, runs the ALU and writes Rd.
// Optional macro REGOP_SAME_SRC_EN: skip the second read when rn == rm.
module regop_sequencer #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic             clk,
    input  logic             reset,
    regop_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_opcode;
    logic [1:0]    r_shift;
    logic [AW-1:0] r_rn;
    logic [AW-1:0] r_rm;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_c;
    logic [AW-1:0] r_readnum;
    logic [AW-1:0] r_writenum;
    logic          r_write;
    logic          r_busy;
    logic          r_done;
    logic [2:0]    r_status;
    logic          w_same_src;
    logic [DW-1:0] w_bsh;
    logic [DW-1:0] w_binv;
    logic [DW-1:0] w_c;
    logic          w_ovf;

    function automatic logic [DW-1:0] f_shift(input logic [DW-1:0] b, input logic [1:0] sh);
        logic [DW-1:0] res;
        case (sh)
            2'b00:   res = b;
            2'b01:   res = {b[DW-2:0], 1'b0};
            2'b10:   res = {1'b0, b[DW-1:1]};
            2'b11:   res = {b[DW-1], b[DW-1:1]};
            default: res = b;
        endcase
        return res;
    endfunction

    // Two's-complement overflow: operands agree in sign, result disagrees
    function automatic logic f_add_ovf(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                       input logic [DW-1:0] s);
        return (x[DW-1] == y[DW-1]) && (s[DW-1] != x[DW-1]);
    endfunction

`ifdef REGOP_SAME_SRC_EN
    assign w_same_src = (r_rn == r_rm);
`else
    assign w_same_src = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_RDA;
                else           w_next = S_IDLE;
            end
            S_RDA: begin
                if (w_same_src) w_next = S_EXEC;
                else            w_next = S_RDB;
            end
            S_RDB:   w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Shifter and ALU; SUB is A + ~Bsh + 1
    always_comb begin
        w_bsh  = f_shift(r_b, r_shift);
        w_binv = ~w_bsh;
        w_c    = {DW{1'b0}};
        w_ovf  = 1'b0;
        case (r_opcode)
            2'b00: begin
                w_c   = r_a + w_bsh;
                w_ovf = f_add_ovf(r_a, w_bsh, w_c);
            end
            2'b01: begin
                w_c   = r_a + w_binv + {{(DW-1){1'b0}}, 1'b1};
                w_ovf = f_add_ovf(r_a, w_binv, w_c);
            end
            2'b10: begin
                w_c   = r_a & w_bsh;
                w_ovf = 1'b0;
            end
            2'b11: begin
                w_c   = w_binv;
                w_ovf = 1'b0;
            end
            default: begin
                w_c   = {DW{1'b0}};
                w_ovf = 1'b0;
            end
        endcase
    end

    // Request capture; inputs are ignored until the FSM returns to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode <= 2'b00;
            r_shift  <= 2'b00;
            r_rn     <= {AW{1'b0}};
            r_rm     <= {AW{1'b0}};
            r_rd     <= {AW{1'b0}};
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_opcode <= bus.opcode;
            r_shift  <= bus.shift;
            r_rn     <= bus.rn;
            r_rm     <= bus.rm;
            r_rd     <= bus.rd;
        end
    end

    // Operand, result and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= {DW{1'b0}};
            r_b      <= {DW{1'b0}};
            r_c      <= {DW{1'b0}};
            r_status <= 3'b000;
        end else begin
            if (r_state == S_RDA) begin
                r_a <= bus.rf_data_out;
                if (w_same_src) r_b <= bus.rf_data_out;
            end
            if (r_state == S_RDB) r_b <= bus.rf_data_out;
            if (r_state == S_EXEC) begin
                r_c      <= w_c;
                r_status <= {w_c[DW-1], w_ovf, (w_c == {DW{1'b0}})};
            end
        end
    end

    // Outputs registered from the next state so they align with the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_write    <= 1'b0;
            r_done     <= 1'b0;
            r_readnum  <= {AW{1'b0}};
            r_writenum <= {AW{1'b0}};
        end else begin
            r_busy  <= (w_next != S_IDLE);
            r_write <= (w_next == S_WB);
            r_done  <= (w_next == S_DONE);
            if (w_next == S_RDA)      r_readnum <= bus.rn;
            else if (w_next == S_RDB) r_readnum <= r_rm;
            if (w_next == S_WB)       r_writenum <= r_rd;
        end
    end

    assign bus.readnum  = r_readnum;
    assign bus.writenum = r_writenum;
    assign bus.write    = r_write;
    assign bus.data_in  = r_c;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.status   = r_status;

endmodule

// File: tb/tb_regop_sequencer.sv
// Directed bench for regop_sequencer with an 8x16 register file model and a scoreboard.
module tb_regop_sequencer;
    localparam int DW = 16;
    localparam int AW = 3;
`ifdef REGOP_SAME_SRC_EN
    localparam int LAT_SS = 4;
`else
    localparam int LAT_SS = 5;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regop_sequencer_if #(.DW(DW), .AW(AW)) bus ();
    regop_sequencer #(.DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [DW-1:0] regs [8];
    logic          pre_we;
    logic [AW-1:0] pre_wn;
    logic [DW-1:0] pre_din;

    always @(posedge clk) begin
        if (pre_we)         regs[pre_wn] <= pre_din;
        else if (bus.write) regs[bus.writenum] <= bus.data_in;
    end
    assign bus.rf_data_out = regs[bus.readnum];

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] val;
        logic [2:0]    st;
        int            lat;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] r, input logic [DW-1:0] v);
        pre_we  = 1'b1;
        pre_wn  = r;
        pre_din = v;
        tick();
        pre_we  = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] sh,
                          input logic [AW-1:0] rn, input logic [AW-1:0] rm, input logic [AW-1:0] rd,
                          input logic [DW-1:0] val, input logic [2:0] st, input int lat,
                          input bit poke);
        exp_t e;
        exp_t got;
        int   cyc;
        int   wr;
        e.rd = rd; e.val = val; e.st = st; e.lat = lat;
        sb.push_back(e);
        bus.start = 1'b1; bus.opcode = op; bus.shift = sh;
        bus.rn = rn; bus.rm = rm; bus.rd = rd;
        tick();
        // scramble request inputs: the captured copy must be used
        bus.start = 1'b0; bus.opcode = ~op; bus.shift = ~sh;
        bus.rn = rn ^ 3'd5; bus.rm = rm ^ 3'd6; bus.rd = rd ^ 3'd7;
        cyc = 1;
        wr  = 0;
        while (!bus.done && cyc < 12) begin
            if (bus.write) wr++;
            if (poke && cyc == 2) begin
                check({tag, "_busy_at_poke"}, bus.busy, 1'b1);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, "_done"}, bus.done, 1'b1);
        got = sb.pop_front();
        check({tag, "_latency"}, cyc, got.lat);
        check({tag, "_result"}, regs[got.rd], got.val);
        check({tag, "_status"}, bus.status, got.st);
        check({tag, "_write_cycles"}, wr, 1);
        tick();
        check({tag, "_done_pulse"}, bus.done, 1'b0);
        check({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        int dcnt;
        reset = 1'b1;
        pre_we = 1'b0; pre_wn = 3'd0; pre_din = 16'h0000;
        bus.start = 1'b0; bus.opcode = 2'b00; bus.shift = 2'b00;
        bus.rn = 3'd0; bus.rm = 3'd0; bus.rd = 3'd0;
        tick();
        tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_write", bus.write, 1'b0);
        check("rst_readnum", bus.readnum, 3'd0);
        check("rst_writenum", bus.writenum, 3'd0);
        check("rst_data_in", bus.data_in, 16'h0000);
        check("rst_status", bus.status, 3'b000);
        for (int i = 0; i < 8; i++) preload(i[AW-1:0], 16'h0000);
        reset = 1'b0;
        tick();

        preload(3'd3, 16'h002A);
        preload(3'd7, 16'hFF98);
        run_op("add_neg", 2'b00, 2'b00, 3'd3, 3'd7, 3'd1, 16'hFFC2, 3'b100, 5, 1'b0);
        run_op("sub_same", 2'b01, 2'b00, 3'd3, 3'd3, 3'd2, 16'h0000, 3'b001, LAT_SS, 1'b0);
        check("r3_kept", regs[3], 16'h002A);

        preload(3'd4, 16'h7FFF);
        preload(3'd5, 16'h0001);
        run_op("add_ovf", 2'b00, 2'b00, 3'd4, 3'd5, 3'd6, 16'h8000, 3'b110, 5, 1'b0);

        // abort during EXEC: no write, outputs cleared at once
        bus.start = 1'b1; bus.opcode = 2'b00; bus.shift = 2'b00;
        bus.rn = 3'd3; bus.rm = 3'd7; bus.rd = 3'd5;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("pre_abort_write", bus.write, 1'b0);
        reset = 1'b1;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_write", bus.write, 1'b0);
        check("abort_readnum", bus.readnum, 3'd0);
        check("abort_writenum", bus.writenum, 3'd0);
        check("abort_data_in", bus.data_in, 16'h0000);
        check("abort_status", bus.status, 3'b000);
        tick();
        check("abort_hold_write", bus.write, 1'b0);
        reset = 1'b0;
        tick();
        check("r5_unchanged", regs[5], 16'h0001);

        run_op("not_asr", 2'b11, 2'b11, 3'd0, 3'd7, 3'd6, 16'h0033, 3'b000, 5, 1'b0);
        run_op("and_lsr", 2'b10, 2'b10, 3'd7, 3'd3, 3'd0, 16'h0010, 3'b000, 5, 1'b1);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) dcnt++;
            tick();
        end
        check("poke_ignored", dcnt, 0);

        run_op("add_same", 2'b00, 2'b00, 3'd3, 3'd3, 3'd4, 16'h0054, 3'b000, LAT_SS, 1'b0);
        check("r5_final", regs[5], 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
